// File: rtl/parity_ui_pkg.sv
// Shared types and constants for the parity counter button front panel.
// Mode encoding is also driven straight onto the status LEDs.
package parity_ui_pkg;

  localparam int DB_CNT_DEFAULT = 250000;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    ODD_M  = 2'b01,
    EVEN_M = 2'b10
  } mode_e;

  // Mode rotation; the unused 11 code falls back to NORMAL
  function automatic mode_e next_mode(input mode_e cur, input logic adv);
    case (cur)
      NORMAL:  next_mode = adv ? ODD_M  : NORMAL;
      ODD_M:   next_mode = adv ? EVEN_M : ODD_M;
      EVEN_M:  next_mode = adv ? NORMAL : EVEN_M;
      default: next_mode = NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw push-button: 2-flop synchronizer, counter debounce and a
// one-cycle press pulse on the debounced 0->1 edge. The pulse is
// registered together with the level update, so it appears DB_CNT+2
// edges after a clean raw rise.
module button_debounce
  import parity_ui_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CNT + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronize, count consecutive disagreeing cycles, accept on the DB_CNT-th
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/parity_button_ctrl.sv
// Front-panel controller for the parity counter: three debounced buttons
// drive a mode rotation (NORMAL/ODD/EVEN), a pause toggle and a clear
// request. All outputs are registered.
// Build option: define HOLD_RESET_EN to keep RESET asserted (and PAUSE
// forced low) for as long as the debounced CLR button stays pressed;
// otherwise a CLR press yields a single-cycle RESET pulse.
module parity_button_ctrl
  import parity_ui_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_MODE,
  input  logic       BTN_PAUSE,
  input  logic       BTN_CLR,
  output logic       EVEN,
  output logic       ODD,
  output logic       PAUSE,
  output logic       RESET,
  output logic [1:0] MODE
);

  mode_e mode_q;
  logic  mode_press, pause_press, clr_press;
`ifdef HOLD_RESET_EN
  logic  clr_level;
`endif

  button_debounce #(.DB_CNT(DB_CNT)) u_db_mode (
    .CLK(CLK), .RST_N(RST_N), .btn(BTN_MODE), .level(), .press(mode_press)
  );

  button_debounce #(.DB_CNT(DB_CNT)) u_db_pause (
    .CLK(CLK), .RST_N(RST_N), .btn(BTN_PAUSE), .level(), .press(pause_press)
  );

  button_debounce #(.DB_CNT(DB_CNT)) u_db_clr (
    .CLK(CLK), .RST_N(RST_N), .btn(BTN_CLR),
`ifdef HOLD_RESET_EN
    .level(clr_level),
`else
    .level(),
`endif
    .press(clr_press)
  );

  assign MODE = mode_q;

  // Mode FSM and registered outputs; RESET sits high through reset so the
  // downstream counter gets a power-up clear, dropping on the first edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= NORMAL;
      EVEN   <= 1'b0;
      ODD    <= 1'b0;
      PAUSE  <= 1'b0;
      RESET  <= 1'b1;
    end else begin
      mode_q <= next_mode(mode_q, mode_press);
      EVEN   <= (next_mode(mode_q, mode_press) == EVEN_M);
      ODD    <= (next_mode(mode_q, mode_press) == ODD_M);
`ifdef HOLD_RESET_EN
      RESET <= clr_level;
      if (clr_level)        PAUSE <= 1'b0;
      else if (pause_press) PAUSE <= ~PAUSE;
`else
      RESET <= clr_press;
      if (clr_press)        PAUSE <= 1'b0;
      else if (pause_press) PAUSE <= ~PAUSE;
`endif
    end
  end

endmodule

// File: tb/tb_parity_button_ctrl.sv
// Directed bench for parity_button_ctrl with DB_CNT = 4: a clean press
// shows on the outputs 7 edges after the raw rise.
module tb_parity_button_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_MODE = 1'b0, BTN_PAUSE = 1'b0, BTN_CLR = 1'b0;
  logic       EVEN, ODD, PAUSE, RESET;
  logic [1:0] MODE;

  int n_chk  = 0;
  int n_fail = 0;

  parity_button_ctrl #(.DB_CNT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .BTN_MODE(BTN_MODE), .BTN_PAUSE(BTN_PAUSE), .BTN_CLR(BTN_CLR),
    .EVEN(EVEN), .ODD(ODD), .PAUSE(PAUSE), .RESET(RESET), .MODE(MODE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset held 3 cycles
    tick(3);
    chk("rst_reset", RESET, 1);
    chk("rst_mode", MODE, 0);
    chk("rst_even", EVEN, 0);
    chk("rst_odd", ODD, 0);
    chk("rst_pause", PAUSE, 0);
    RST_N = 1'b1;
    tick(1);
    chk("rst_release_reset", RESET, 0);
    chk("rst_release_mode", MODE, 0);

    // three mode presses, each held 10 cycles
    BTN_MODE = 1'b1;
    tick(6);
    chk("mode1_edge6", MODE, 0);
    tick(1);
    chk("mode1_edge7", MODE, 1);
    chk("mode1_odd", ODD, 1);
    chk("mode1_even", EVEN, 0);
    tick(3);
    BTN_MODE = 1'b0;
    tick(10);
    chk("mode1_release", MODE, 1);

    BTN_MODE = 1'b1;
    tick(7);
    chk("mode2", MODE, 2);
    chk("mode2_even", EVEN, 1);
    chk("mode2_odd", ODD, 0);
    tick(3);
    BTN_MODE = 1'b0;
    tick(10);

    BTN_MODE = 1'b1;
    tick(7);
    chk("mode3", MODE, 0);
    chk("mode3_even", EVEN, 0);
    chk("mode3_odd", ODD, 0);
    tick(3);
    BTN_MODE = 1'b0;
    tick(10);

    // bouncing pause button then steady: one toggle
    BTN_PAUSE = 1'b1; tick(1);
    BTN_PAUSE = 1'b0; tick(1);
    BTN_PAUSE = 1'b1; tick(1);
    chk("bounce_mid", PAUSE, 0);
    BTN_PAUSE = 1'b0; tick(1);
    BTN_PAUSE = 1'b1;
    tick(6);
    chk("bounce_edge6", PAUSE, 0);
    tick(1);
    chk("bounce_edge7", PAUSE, 1);
    tick(5);
    chk("bounce_held", PAUSE, 1);
    BTN_PAUSE = 1'b0;
    tick(10);
    chk("pause_release", PAUSE, 1);

    // toggle back to 0
    BTN_PAUSE = 1'b1;
    tick(7);
    chk("pause_toggle_back", PAUSE, 0);
    BTN_PAUSE = 1'b0;
    tick(10);

    // pause and clear together while PAUSE = 0
    BTN_PAUSE = 1'b1;
    BTN_CLR   = 1'b1;
    tick(6);
    chk("clr_edge6", RESET, 0);
    tick(1);
    chk("clr_edge7_reset", RESET, 1);
    chk("clr_edge7_pause", PAUSE, 0);
    tick(1);
`ifdef HOLD_RESET_EN
    chk("clr_edge8_reset", RESET, 1);
`else
    chk("clr_edge8_reset", RESET, 0);
`endif
    chk("clr_edge8_pause", PAUSE, 0);
    chk("clr_mode", MODE, 0);
    tick(2);
    BTN_PAUSE = 1'b0;
    BTN_CLR   = 1'b0;
    tick(6);
`ifdef HOLD_RESET_EN
    chk("clr_hold_tail", RESET, 1);
`else
    chk("clr_hold_tail", RESET, 0);
`endif
    tick(1);
    chk("clr_after_release", RESET, 0);
    chk("clr_after_pause", PAUSE, 0);
    tick(5);

    // mode and pause events in the same cycle are independent
    BTN_MODE  = 1'b1;
    BTN_PAUSE = 1'b1;
    tick(7);
    chk("both_mode", MODE, 1);
    chk("both_pause", PAUSE, 1);
    BTN_MODE  = 1'b0;
    BTN_PAUSE = 1'b0;
    tick(10);

    // clear alone forces PAUSE low, MODE untouched
    BTN_CLR = 1'b1;
    tick(7);
    chk("clr2_reset", RESET, 1);
    chk("clr2_pause", PAUSE, 0);
    chk("clr2_mode", MODE, 1);
    BTN_CLR = 1'b0;
    tick(10);
    chk("clr2_done", RESET, 0);

    // reset pulsed mid-debounce (count = 2), button kept held
    BTN_MODE = 1'b1;
    tick(4);
    RST_N = 1'b0;
    #1;
    chk("midrst_reset", RESET, 1);
    chk("midrst_mode", MODE, 0);
    tick(3);
    chk("midrst_held_mode", MODE, 0);
    RST_N = 1'b1;
    tick(1);
    chk("midrst_release_reset", RESET, 0);
    tick(5);
    chk("midrst_edge6", MODE, 0);
    tick(1);
    chk("midrst_edge7", MODE, 1);
    chk("midrst_odd", ODD, 1);
    BTN_MODE = 1'b0;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_button_ctrl.md
PARITY_BUTTON_CTRL -- requirements
Module: parity_button_ctrl

Interface
REQ-001 SHALL have parameter: DB_CNT, default 250000, number of consecutive stable CLK cycles needed to accept a button change (minimum 2).
REQ-002 SHALL have port: CLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: BTN_MODE  input  1  raw push-button, active-high, asynchronous to CLK.
REQ-005 SHALL have port: BTN_PAUSE  input  1  raw push-button, active-high, asynchronous.
REQ-006 SHALL have port: BTN_CLR  input  1  raw push-button, active-high, asynchronous.
REQ-007 SHALL have port: EVEN  output  1  registered even-count select for the downstream parity counter.
REQ-008 SHALL have port: ODD  output  1  registered odd-count select.
REQ-009 SHALL have port: PAUSE  output  1  registered hold request.
REQ-010 SHALL have port: RESET  output  1  registered synchronous clear request, active-high.
REQ-011 SHALL have port: MODE  output  2  current mode code, for status LEDs.

Function
REQ-012 SHALL pass each raw button through a 2-flop synchronizer.
REQ-013 SHALL, per button, keep a debounced level and a counter of width $clog2(DB_CNT+1); the counter increments each cycle the synchronized input differs from the debounced level and clears whenever they match.
REQ-014 SHALL update the debounced level, and clear the counter, on the DB_CNT-th consecutive differing cycle.
REQ-015 SHALL generate a one-cycle press event only on a debounced 0->1 transition; releases generate no event.
REQ-016 SHALL produce no event for any raw pulse or bounce shorter than DB_CNT cycles.
REQ-017 SHALL make a clean raw press visible on outputs exactly DB_CNT+3 CLK edges after the raw rise (2 sync, DB_CNT debounce, 1 output register).
REQ-018 SHALL implement mode FSM NORMAL(00) -> ODD_M(01) -> EVEN_M(10) -> NORMAL, advancing once per MODE press event; code 11 is unreachable and, if entered, SHALL return to NORMAL on the next edge.
REQ-019 SHALL drive EVEN/ODD = 0/0 in NORMAL, 0/1 in ODD_M, 1/0 in EVEN_M; never 1/1.
REQ-020 SHALL toggle PAUSE on each PAUSE press event.
REQ-021 SHALL, on a CLR press event, assert RESET for exactly one cycle and force PAUSE to 0 in the same cycle; MODE is unaffected.
REQ-022 SHALL give CLR priority over PAUSE when both press events occur in the same cycle (PAUSE = 0).
REQ-023 SHALL process MODE press events independently of CLR and PAUSE events in the same cycle.

Reset
REQ-024 SHALL, while RST_N = 0, hold synchronizers, debounced levels and counters at 0, MODE = NORMAL, EVEN = ODD = PAUSE = 0, and RESET = 1.
REQ-025 SHALL deassert RESET on the first CLK edge after RST_N rises, giving the downstream counter a power-up clear.
REQ-026 SHALL discard any debounce in progress when RST_N falls mid-operation; a button still held after release of reset counts as a fresh press.

Configuration
REQ-027 SHALL, with HOLD_RESET_EN defined, drive RESET high for as long as the debounced CLR level is 1, starting in the cycle of the press event, and hold PAUSE at 0 for that whole time.
REQ-028 SHALL, without HOLD_RESET_EN, behave as REQ-021 (single-cycle RESET pulse).

Structure
REQ-029 SHALL place the mode enum typedef (NORMAL, ODD_M, EVEN_M), its 2-bit encodings and the default DB_CNT constant in shared package parity_ui_pkg.
REQ-030 SHALL implement synchronizer + debounce + press-event detection as sub-module button_debounce (parameter DB_CNT), instantiated three times.

Verification (DB_CNT = 4)
REQ-031 SHALL cover: RST_N low 3 cycles then high -> RESET = 1 during reset, 0 after first edge; MODE = 00, EVEN = ODD = PAUSE = 0.
REQ-032 SHALL cover: BTN_MODE high 10 cycles, three separate presses -> MODE 01 (ODD = 1) at edge 7 after the first rise, then 10 (EVEN = 1), then 00.
REQ-033 SHALL cover: BTN_PAUSE bouncing 1,0,1,0 per cycle, then steady 1 -> exactly one PAUSE toggle, 0 -> 1.
REQ-034 SHALL cover: BTN_PAUSE and BTN_CLR rising on the same edge with PAUSE = 0 -> RESET high one cycle (level for button hold with HOLD_RESET_EN), PAUSE stays 0.
REQ-035 SHALL cover: RST_N pulsed low while BTN_MODE debounce count = 2 -> no mode change, counter restarts, press accepted DB_CNT+3 edges after reset release if still held.
